// File: rtl/program_loader_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : program_loader_ctrl_if
// Description : UART byte input plus instruction-memory write port and
//               core-control outputs of the program loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface program_loader_ctrl_if #(
    parameter int INST_MEM_WIDTH = 2
);
    logic                      load_req;
    logic [7:0]                rx_data;
    logic                      rx_valid;
    logic                      wr_en;
    logic [INST_MEM_WIDTH-1:0] wr_addr;
    logic [31:0]               wr_data;
    logic                      cpu_run;
    logic                      cpu_reset;
    logic                      busy;
    logic                      error;
    logic [INST_MEM_WIDTH:0]   words_loaded;

    modport master (
        output load_req, rx_data, rx_valid,
        input  wr_en, wr_addr, wr_data, cpu_run, cpu_reset, busy, error, words_loaded
    );

    modport slave (
        input  load_req, rx_data, rx_valid,
        output wr_en, wr_addr, wr_data, cpu_run, cpu_reset, busy, error, words_loaded
    );
endinterface
`default_nettype wire

// File: rtl/program_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : program_loader_ctrl
// Description : Parses a word-count header from UART bytes, writes the
//               following 32-bit words to instruction memory and restarts
//               the core once the image is complete.
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader_ctrl #(
    parameter int INST_MEM_WIDTH = 2
) (
    input wire                   CLK,
    input wire                   reset,
    program_loader_ctrl_if.slave bus
);
    localparam int          W          = INST_MEM_WIDTH;
    localparam logic [32:0] c_capacity = 33'(1) << W;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_DATA = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t         r_state;
    logic [1:0]     r_byte_cnt;
    logic [23:0]    r_shift;
    logic [W:0]     r_n_words;
    logic [W:0]     r_words_loaded;
    logic           r_wr_en;
    logic [W-1:0]   r_wr_addr;
    logic [31:0]    r_wr_data;
    logic           r_cpu_run;
    logic           r_cpu_reset;
    logic           r_busy;
    logic           r_error;

    logic [31:0]    w_word;
    logic [W:0]     w_words_next;

    // The current byte completes a big-endian word together with the three
    // previously shifted-in bytes of the same group.
    assign w_word       = {r_shift, bus.rx_data};
    assign w_words_next = r_words_loaded + (W+1)'(1);

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_byte_cnt     <= 2'd0;
            r_shift        <= 24'd0;
            r_n_words      <= '0;
            r_words_loaded <= '0;
            r_wr_en        <= 1'b0;
            r_wr_addr      <= '0;
            r_wr_data      <= 32'd0;
            r_cpu_run      <= 1'b1;
            r_cpu_reset    <= 1'b0;
            r_busy         <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_wr_en     <= 1'b0;
            r_cpu_reset <= 1'b0;

            // A load request restarts from any state and drops a coincident byte.
            if (bus.load_req) begin
                r_state        <= S_HDR;
                r_busy         <= 1'b1;
                r_cpu_run      <= 1'b0;
                r_error        <= 1'b0;
                r_words_loaded <= '0;
                r_byte_cnt     <= 2'd0;
                r_shift        <= 24'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_busy <= 1'b0;
                    end

                    S_HDR, S_DATA: begin
                        if (bus.rx_valid) begin
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                            r_shift    <= {r_shift[15:0], bus.rx_data};
                            if (r_byte_cnt == 2'd3) begin
                                if (r_state == S_HDR) begin
                                    // Full 32-bit count against capacity so
                                    // large headers cannot alias to small ones.
                                    if ({1'b0, w_word} > c_capacity) begin
                                        r_state <= S_ERR;
                                        r_error <= 1'b1;
                                        r_busy  <= 1'b0;
                                    end else if (w_word == 32'd0) begin
                                        r_state     <= S_DONE;
                                        r_cpu_reset <= 1'b1;
                                    end else begin
                                        r_state   <= S_DATA;
                                        r_n_words <= w_word[W:0];
                                    end
                                end else begin
                                    r_wr_en        <= 1'b1;
                                    r_wr_addr      <= r_words_loaded[W-1:0];
                                    r_wr_data      <= w_word;
                                    r_words_loaded <= w_words_next;
                                    if (w_words_next == r_n_words) begin
                                        r_state     <= S_DONE;
                                        r_cpu_reset <= 1'b1;
                                    end
                                end
                            end
                        end
                    end

                    S_DONE: begin
                        r_state   <= S_IDLE;
                        r_cpu_run <= 1'b1;
                        r_busy    <= 1'b0;
                    end

                    S_ERR: begin
                        r_error   <= 1'b1;
                        r_cpu_run <= 1'b0;
                        r_busy    <= 1'b0;
                    end

                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.wr_en        = r_wr_en;
    assign bus.wr_addr      = r_wr_addr;
    assign bus.wr_data      = r_wr_data;
    assign bus.cpu_run      = r_cpu_run;
    assign bus.cpu_reset    = r_cpu_reset;
    assign bus.busy         = r_busy;
    assign bus.error        = r_error;
    assign bus.words_loaded = r_words_loaded;

endmodule
`default_nettype wire
